// File: rtl/adma_desc_fetch_if.sv
// Memory-read and descriptor-handoff signals of the ADMA descriptor fetcher.
// master = the fetcher, slave = memory/engine side (or a testbench standing in for it).
interface adma_desc_fetch_if;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  logic        desc_valid;
  logic        desc_ready;
  logic [63:0] desc_addr;
  logic [16:0] desc_len;
  logic        desc_int;
  logic        desc_end;

  modport master (
    output mem_req, mem_addr,
    input  mem_rdata, mem_ack, mem_err,
    output desc_valid, desc_addr, desc_len, desc_int, desc_end,
    input  desc_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_rdata, mem_ack, mem_err,
    input  desc_valid, desc_addr, desc_len, desc_int, desc_end,
    output desc_ready
  );
endinterface

// File: rtl/adma_desc_fetch.sv
// ADMA descriptor-chain walker: fetches descriptors word by word, follows Links, skips Nops
// and presents Tran descriptors. Define ADMA_ADDR64_EN for 3-word descriptors with 64-bit addresses.
module adma_desc_fetch #(
  parameter int unsigned LINK_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [63:0]              Initial_ADMA_System_Address,
  adma_desc_fetch_if.master        bus,
  output logic                     busy,
  output logic                     fetch_done,
  output logic                     fetch_error,
  output logic [63:0]              cur_desc_addr
);

`ifdef ADMA_ADDR64_EN
  localparam logic [1:0]  LAST_WORD = 2'd2;
  localparam logic [63:0] STRIDE    = 64'd12;
  localparam logic [63:0] ADDR_MASK = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [1:0]  LAST_WORD = 2'd1;
  localparam logic [63:0] STRIDE    = 64'd8;
  localparam logic [63:0] ADDR_MASK = 64'h0000_0000_FFFF_FFFF;
`endif
  localparam int unsigned    LW       = $clog2(LINK_LIMIT + 1);
  localparam logic [LW-1:0]  LINK_MAX = LW'(LINK_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_PRESENT, S_DONE, S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   cur_q, cur_d;
  logic [1:0]    widx_q, widx_d;
  logic [LW-1:0] link_q, link_d, link_inc;
  logic [31:0]   word0_q, word0_d, word1_q, word1_d;
`ifdef ADMA_ADDR64_EN
  logic [31:0]   word2_q, word2_d;
`endif
  logic          mem_req_q, mem_req_d;
  logic [63:0]   mem_addr_q, mem_addr_d;
  logic          desc_valid_q, desc_valid_d;
  logic [63:0]   desc_addr_q, desc_addr_d;
  logic [16:0]   desc_len_q, desc_len_d;
  logic          desc_int_q, desc_int_d, desc_end_q, desc_end_d;
  logic          busy_q, busy_d, fetch_done_q, fetch_done_d, fetch_error_q, fetch_error_d;

  logic          d_valid, d_end, d_int;
  logic [1:0]    d_act;
  logic [15:0]   d_len;
  logic [63:0]   d_tgt, next_desc;
  logic          unused_word0_bits;

  // In 32-bit mode every address is confined to the low 4 GiB.
  function automatic logic [63:0] fix_addr(input logic [63:0] a);
    return a & ADDR_MASK;
  endfunction

  assign d_valid  = word0_q[0];
  assign d_end    = word0_q[1];
  assign d_int    = word0_q[2];
  assign d_act    = word0_q[5:4];
  assign d_len    = word0_q[31:16];
`ifdef ADMA_ADDR64_EN
  assign d_tgt    = fix_addr({word2_q, word1_q});
`else
  assign d_tgt    = fix_addr({32'h0, word1_q});
`endif
  assign next_desc = fix_addr(cur_q + STRIDE);
  assign link_inc  = link_q + LW'(1);
  assign unused_word0_bits = ^{word0_q[15:6], word0_q[3]};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cur_d        = cur_q;
    widx_d       = widx_q;
    link_d       = link_q;
    word0_d      = word0_q;
    word1_d      = word1_q;
`ifdef ADMA_ADDR64_EN
    word2_d      = word2_q;
`endif
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    desc_valid_d = desc_valid_q;
    desc_addr_d  = desc_addr_q;
    desc_len_d   = desc_len_q;
    desc_int_d   = desc_int_q;
    desc_end_d   = desc_end_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          cur_d      = fix_addr(Initial_ADMA_System_Address);
          widx_d     = 2'd0;
          link_d     = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = fix_addr(Initial_ADMA_System_Address);
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fix_addr(cur_q + {60'h0, widx_q, 2'b00});
        end else if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          if (bus.mem_err) begin
            state_d = S_ERROR;
          end else begin
            if (widx_q == 2'd0) word0_d = bus.mem_rdata;
            if (widx_q == 2'd1) word1_d = bus.mem_rdata;
`ifdef ADMA_ADDR64_EN
            if (widx_q == 2'd2) word2_d = bus.mem_rdata;
`endif
            if (widx_q == LAST_WORD) begin
              widx_d  = 2'd0;
              state_d = S_DECODE;
            end else begin
              widx_d  = widx_q + 2'd1;
            end
          end
        end
      end

      S_DECODE: begin
        if (!d_valid) begin
          state_d = S_ERROR;
        end else if (d_act == 2'b10) begin
          desc_addr_d  = d_tgt;
          desc_len_d   = (d_len == 16'h0) ? 17'h1_0000 : {1'b0, d_len};
          desc_int_d   = d_int;
          desc_end_d   = d_end;
          desc_valid_d = 1'b1;
          state_d      = S_PRESENT;
        end else if (d_act == 2'b11) begin
          cur_d  = d_tgt;
          link_d = link_inc;
          if (link_inc >= LINK_MAX) begin
            state_d = S_ERROR;
          end else if (d_end) begin
            state_d = S_DONE;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = d_tgt;
            state_d    = S_FETCH;
          end
        end else if (d_end) begin
          state_d = S_DONE;
        end else begin
          cur_d      = next_desc;
          mem_req_d  = 1'b1;
          mem_addr_d = next_desc;
          state_d    = S_FETCH;
        end
      end

      S_PRESENT: begin
        if (bus.desc_ready) begin
          desc_valid_d = 1'b0;
          link_d       = '0;
          if (desc_end_q) begin
            state_d = S_DONE;
          end else begin
            cur_d      = next_desc;
            mem_req_d  = 1'b1;
            mem_addr_d = next_desc;
            state_d    = S_FETCH;
          end
        end
      end

      default: state_d = S_IDLE;  // DONE, ERROR: one pulse cycle, then back to IDLE
    endcase

    // Abort wins over whatever the state logic decided, and suppresses the done/error pulse.
    if (stop) begin
      state_d      = S_IDLE;
      mem_req_d    = 1'b0;
      desc_valid_d = 1'b0;
    end

    fetch_done_d  = (state_d == S_DONE);
    fetch_error_d = (state_d == S_ERROR);
    busy_d        = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      widx_q        <= '0;
      link_q        <= '0;
      word0_q       <= '0;
      word1_q       <= '0;
`ifdef ADMA_ADDR64_EN
      word2_q       <= '0;
`endif
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      desc_valid_q  <= 1'b0;
      desc_addr_q   <= '0;
      desc_len_q    <= '0;
      desc_int_q    <= 1'b0;
      desc_end_q    <= 1'b0;
      busy_q        <= 1'b0;
      fetch_done_q  <= 1'b0;
      fetch_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      widx_q        <= widx_d;
      link_q        <= link_d;
      word0_q       <= word0_d;
      word1_q       <= word1_d;
`ifdef ADMA_ADDR64_EN
      word2_q       <= word2_d;
`endif
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      desc_valid_q  <= desc_valid_d;
      desc_addr_q   <= desc_addr_d;
      desc_len_q    <= desc_len_d;
      desc_int_q    <= desc_int_d;
      desc_end_q    <= desc_end_d;
      busy_q        <= busy_d;
      fetch_done_q  <= fetch_done_d;
      fetch_error_q <= fetch_error_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.desc_valid = desc_valid_q;
  assign bus.desc_addr  = desc_addr_q;
  assign bus.desc_len   = desc_len_q;
  assign bus.desc_int   = desc_int_q;
  assign bus.desc_end   = desc_end_q;
  assign busy           = busy_q;
  assign fetch_done     = fetch_done_q;
  assign fetch_error    = fetch_error_q;
  assign cur_desc_addr  = cur_q;

endmodule

// File: tb/tb_adma_desc_fetch.sv
// Directed bench for adma_desc_fetch (default 32-bit build): memory responder model,
// protocol monitor and one task per scenario with hand-computed expectations.
module tb_adma_desc_fetch;
  logic        clk = 1'b0;
  logic        rst_n, start, stop;
  logic [63:0] init_addr;
  logic        busy, fetch_done, fetch_error;
  logic [63:0] cur_desc_addr;

  adma_desc_fetch_if bus();

  adma_desc_fetch #(.LINK_LIMIT(16)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .start                       (start),
    .stop                        (stop),
    .Initial_ADMA_System_Address (init_addr),
    .bus                         (bus.master),
    .busy                        (busy),
    .fetch_done                  (fetch_done),
    .fetch_error                 (fetch_error),
    .cur_desc_addr               (cur_desc_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_model [logic [63:0]];
  logic [63:0] addr_log [$];
  bit          resp_en   = 1'b1;
  int          ack_delay = 0;
  logic [63:0] err_addr  = '1;

  int          done_cnt = 0, err_cnt = 0, dv_cyc = 0, hs_cnt = 0, proto_viol = 0;
  logic [63:0] hs_addr = '0;
  logic [16:0] hs_len  = '0;
  logic        hs_int  = 1'b0, hs_end = 1'b0;

  // Memory responder: answers a pending request after ack_delay waiting cycles.
  initial begin
    int wait_cnt;
    wait_cnt      = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_err   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_err = 1'b0;
      if (rst_n && resp_en && bus.mem_req) begin
        if (wait_cnt >= ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : 32'h0;
          bus.mem_err   = (bus.mem_addr == err_addr);
          addr_log.push_back(bus.mem_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: samples exactly what the DUT sees at each rising edge.
  initial begin
    bit          prev_wait, prev_hs;
    logic [63:0] prev_addr;
    prev_wait = 1'b0;
    prev_hs   = 1'b0;
    prev_addr = '0;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (fetch_done)  done_cnt++;
        if (fetch_error) err_cnt++;
        if (bus.desc_valid) dv_cyc++;
        if (bus.desc_valid && bus.desc_ready) begin
          hs_cnt++;
          hs_addr = bus.desc_addr;
          hs_len  = bus.desc_len;
          hs_int  = bus.desc_int;
          hs_end  = bus.desc_end;
        end
        if (prev_wait && bus.mem_req && bus.mem_addr != prev_addr) proto_viol++;
        if (prev_hs && bus.mem_req) proto_viol++;
        prev_wait = bus.mem_req && !bus.mem_ack;
        prev_hs   = bus.mem_req && bus.mem_ack;
        prev_addr = bus.mem_addr;
      end else begin
        prev_wait = 1'b0;
        prev_hs   = 1'b0;
      end
    end
  end

  function automatic logic [63:0] log_at(input int i);
    return (i < addr_log.size()) ? addr_log[i] : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic start_chain(input logic [63:0] a);
    @(negedge clk);
    init_addr = a;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({busy, fetch_done, fetch_error, bus.mem_req, bus.desc_valid, bus.desc_int, bus.desc_end} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000000",
               {busy, fetch_done, fetch_error, bus.mem_req, bus.desc_valid, bus.desc_int, bus.desc_end});
    end
    total++;
    if ({cur_desc_addr, bus.mem_addr, bus.desc_addr, bus.desc_len} !== 209'h0) begin
      bad++;
      $display("FAIL reset_fields: cur=%h mem_addr=%h desc_addr=%h len=%h want all 0",
               cur_desc_addr, bus.mem_addr, bus.desc_addr, bus.desc_len);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_tran();
    int b, d0, e0, h0, p0;
    bit ok;
    mem_model[64'h1000] = 32'h0200_0023;
    mem_model[64'h1004] = 32'h8000_0000;
    bus.desc_ready = 1'b1;
    b = addr_log.size(); d0 = done_cnt; e0 = err_cnt; h0 = hs_cnt; p0 = proto_viol;
    start_chain(64'h1000);
    wait_idle(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: busy=%b want 0", busy); end
    total++; if (addr_log.size() - b != 2) begin bad++; $display("FAIL single_nreads: got %0d want 2", addr_log.size() - b); end
    total++; if (log_at(b) !== 64'h1000) begin bad++; $display("FAIL single_addr0: got %h want 1000", log_at(b)); end
    total++; if (log_at(b+1) !== 64'h1004) begin bad++; $display("FAIL single_addr1: got %h want 1004", log_at(b+1)); end
    total++; if (hs_cnt - h0 != 1) begin bad++; $display("FAIL single_hs: got %0d want 1", hs_cnt - h0); end
    total++; if (hs_addr !== 64'h8000_0000) begin bad++; $display("FAIL single_desc_addr: got %h want 80000000", hs_addr); end
    total++; if (hs_len !== 17'd512) begin bad++; $display("FAIL single_desc_len: got %0d want 512", hs_len); end
    total++; if ({hs_int, hs_end} !== 2'b01) begin bad++; $display("FAIL single_int_end: got %b want 01", {hs_int, hs_end}); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_done: got %0d want 1", done_cnt - d0); end
    total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL single_err: got %0d want 0", err_cnt - e0); end
    total++; if (proto_viol - p0 != 0) begin bad++; $display("FAIL single_proto: got %0d want 0", proto_viol - p0); end
  endtask

  task automatic test_link();
    int b, d0;
    bit ok;
    mem_model[64'h1800] = 32'h0000_0031;
    mem_model[64'h1804] = 32'h0000_2000;
    mem_model[64'h2000] = 32'h0000_0023;
    mem_model[64'h2004] = 32'h0000_5000;
    b = addr_log.size(); d0 = done_cnt;
    start_chain(64'h1800);
    wait_idle(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL link_timeout: busy=%b want 0", busy); end
    total++; if (addr_log.size() - b != 4) begin bad++; $display("FAIL link_nreads: got %0d want 4", addr_log.size() - b); end
    total++; if (log_at(b+2) !== 64'h2000) begin bad++; $display("FAIL link_target_fetch: got %h want 2000", log_at(b+2)); end
    total++; if (hs_len !== 17'h1_0000) begin bad++; $display("FAIL link_len65536: got %h want 10000", hs_len); end
    total++; if (hs_addr !== 64'h5000) begin bad++; $display("FAIL link_desc_addr: got %h want 5000", hs_addr); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL link_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_nop_slow_mem();
    int b, p0;
    bit ok;
    mem_model[64'h6000] = 32'h0000_0001;
    mem_model[64'h6004] = 32'h0000_DEAD;
    mem_model[64'h6008] = 32'h0004_0027;
    mem_model[64'h600C] = 32'h0000_7000;
    ack_delay = 2;
    b = addr_log.size(); p0 = proto_viol;
    start_chain(64'h6000);
    wait_idle(200, ok);
    ack_delay = 0;
    total++; if (!ok) begin bad++; $display("FAIL nop_timeout: busy=%b want 0", busy); end
    total++; if (log_at(b+2) !== 64'h6008) begin bad++; $display("FAIL nop_stride: got %h want 6008", log_at(b+2)); end
    total++; if (log_at(b+3) !== 64'h600C) begin bad++; $display("FAIL nop_word1: got %h want 600c", log_at(b+3)); end
    total++; if ({hs_addr, hs_len, hs_int, hs_end} !== {64'h7000, 17'd4, 1'b1, 1'b1})
      begin bad++; $display("FAIL nop_desc: got %h/%0d/%b/%b want 7000/4/1/1", hs_addr, hs_len, hs_int, hs_end); end
    total++; if (proto_viol - p0 != 0) begin bad++; $display("FAIL nop_req_stable: got %0d want 0", proto_viol - p0); end
  endtask

  task automatic test_invalid();
    int d0, e0, v0;
    bit ok;
    mem_model[64'h3000] = 32'h0000_0000;
    mem_model[64'h3004] = 32'h0000_1234;
    d0 = done_cnt; e0 = err_cnt; v0 = dv_cyc;
    start_chain(64'h3000);
    wait_idle(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL invalid_timeout: busy=%b want 0", busy); end
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL invalid_err: got %0d want 1", err_cnt - e0); end
    total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL invalid_done: got %0d want 0", done_cnt - d0); end
    total++; if (cur_desc_addr !== 64'h3000) begin bad++; $display("FAIL invalid_cur: got %h want 3000", cur_desc_addr); end
    total++; if (dv_cyc - v0 != 0) begin bad++; $display("FAIL invalid_dv: got %0d want 0", dv_cyc - v0); end
  endtask

  task automatic test_link_limit();
    int b, d0, e0;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      mem_model[64'h4000 + 64'(16*i)]     = 32'h0000_0031;
      mem_model[64'h4004 + 64'(16*i)]     = 32'h4000 + 32'(16*(i+1));
    end
    b = addr_log.size(); d0 = done_cnt; e0 = err_cnt;
    start_chain(64'h4000);
    wait_idle(500, ok);
    total++; if (!ok) begin bad++; $display("FAIL limit_timeout: busy=%b want 0", busy); end
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL limit_err: got %0d want 1", err_cnt - e0); end
    total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL limit_done: got %0d want 0", done_cnt - d0); end
    total++; if (addr_log.size() - b != 32) begin bad++; $display("FAIL limit_nreads: got %0d want 32", addr_log.size() - b); end
    total++; if (log_at(b+31) !== 64'h40F4) begin bad++; $display("FAIL limit_last_fetch: got %h want 40f4", log_at(b+31)); end
  endtask

  task automatic test_mem_err();
    int d0, e0, h0;
    bit ok;
    mem_model[64'h9000] = 32'h0200_0023;
    mem_model[64'h9004] = 32'h0000_1111;
    err_addr = 64'h9004;
    d0 = done_cnt; e0 = err_cnt; h0 = hs_cnt;
    start_chain(64'h9000);
    wait_idle(100, ok);
    err_addr = '1;
    total++; if (!ok) begin bad++; $display("FAIL memerr_timeout: busy=%b want 0", busy); end
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL memerr_err: got %0d want 1", err_cnt - e0); end
    total++; if ((done_cnt - d0) + (hs_cnt - h0) != 0)
      begin bad++; $display("FAIL memerr_no_desc: done=%0d hs=%0d want 0/0", done_cnt - d0, hs_cnt - h0); end
  endtask

  task automatic test_hold_stop();
    int n, d0, e0;
    mem_model[64'hA000] = 32'h0010_0025;
    mem_model[64'hA004] = 32'h0000_B000;
    bus.desc_ready = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    start_chain(64'hA000);
    n = 0;
    while (!bus.desc_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++; if (bus.desc_valid !== 1'b1) begin bad++; $display("FAIL hold_wait_valid: got %b want 1", bus.desc_valid); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({bus.desc_valid, bus.desc_addr, bus.desc_len, bus.desc_int, bus.desc_end} !==
          {1'b1, 64'hB000, 17'd16, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL hold_stable[%0d]: got %b/%h/%0d/%b/%b want 1/b000/16/1/0", i,
                 bus.desc_valid, bus.desc_addr, bus.desc_len, bus.desc_int, bus.desc_end);
      end
      start     = (i == 4);
      init_addr = 64'hFFFF_0000;
      @(negedge clk);
    end
    start = 1'b0;
    total++; if ({busy, cur_desc_addr} !== {1'b1, 64'hA000})
      begin bad++; $display("FAIL start_ignored: busy=%b cur=%h want 1/a000", busy, cur_desc_addr); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++; if ({busy, bus.desc_valid, bus.mem_req} !== 3'b000)
      begin bad++; $display("FAIL stop_idle: busy/dv/req=%b want 000", {busy, bus.desc_valid, bus.mem_req}); end
    repeat (3) @(negedge clk);
    total++; if ((done_cnt - d0) + (err_cnt - e0) != 0)
      begin bad++; $display("FAIL stop_no_pulse: done=%0d err=%0d want 0/0", done_cnt - d0, err_cnt - e0); end
    bus.desc_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    resp_en = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    start_chain(64'hC000);
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rstmid_req_pending: got %b want 1", bus.mem_req); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.mem_req, bus.desc_valid, busy, fetch_done, fetch_error} !== 5'b0)
      begin bad++; $display("FAIL rstmid_flags: got %b want 00000", {bus.mem_req, bus.desc_valid, busy, fetch_done, fetch_error}); end
    total++; if ({cur_desc_addr, bus.mem_addr, bus.desc_addr, bus.desc_len} !== 209'h0)
      begin bad++; $display("FAIL rstmid_fields: cur=%h mem_addr=%h desc_addr=%h len=%h want 0", cur_desc_addr, bus.mem_addr, bus.desc_addr, bus.desc_len); end
    @(negedge clk);
    rst_n   = 1'b1;
    resp_en = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if ((done_cnt - d0) + (err_cnt - e0) != 0)
      begin bad++; $display("FAIL rstmid_no_pulse: done=%0d err=%0d want 0/0", done_cnt - d0, err_cnt - e0); end
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    init_addr      = '0;
    bus.desc_ready = 1'b0;
    test_reset();
    test_single_tran();
    test_link();
    test_nop_slow_mem();
    test_invalid();
    test_link_limit();
    test_mem_err();
    test_hold_stop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
